// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state type and golden-result rules for alu_sequencer.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1111;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_GT  = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [3:0] sel);
        logic legal;
        case (sel)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_EQ, OP_GT, OP_SHL, OP_SHR, OP_MUL: legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Operands are zero-extended to 8 bits before every operation.
    function automatic logic [7:0] golden(input logic [3:0] sel,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] res;
        ea = {4'b0000, a};
        eb = {4'b0000, b};
        case (sel)
            OP_ADD:  res = ea + eb;
            OP_SUB:  res = ea - eb;
            OP_AND:  res = ea & eb;
            OP_OR:   res = ea | eb;
            OP_XOR:  res = ea ^ eb;
            OP_EQ:   res = {7'b0, (ea == eb)};
            OP_GT:   res = {7'b0, (ea > eb)};
            OP_SHL:  res = ea << eb;
            OP_SHR:  res = ea >> eb;
            OP_MUL:  res = ea * eb;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_seq_check.sv
// Golden comparator: flags a mismatch between the external ALU result and the expected one.
module alu_seq_check
    import alu_pkg::*;
(
    input  logic [3:0] sel_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [7:0] alu_c_i,
    output logic       mismatch_o
);

    logic [7:0] expected;

    always_comb begin
        expected   = golden(sel_i, a_i, b_i);
        mismatch_o = (alu_c_i != expected);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external combinational ALU.
// Optional golden-result checking is enabled by defining ALU_SEQ_CHECK_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] op_count
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] lat_a_q, lat_a_d;
    logic [3:0] lat_b_q, lat_b_d;
    logic [3:0] lat_sel_q, lat_sel_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] op_count_q, op_count_d;
    logic       check_err;

`ifdef ALU_SEQ_CHECK_EN
    logic mismatch;

    alu_seq_check u_check (
        .sel_i      (alu_sel_q),
        .a_i        (alu_a_q),
        .b_i        (alu_b_q),
        .alu_c_i    (alu_c),
        .mismatch_o (mismatch)
    );

    assign check_err = mismatch;
`else
    assign check_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lat_a_q    <= 4'h0;
            lat_b_q    <= 4'h0;
            lat_sel_q  <= 4'h0;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_sel_q  <= 4'h0;
            cnt_q      <= 4'h0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
            op_count_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            lat_a_q    <= lat_a_d;
            lat_b_q    <= lat_b_d;
            lat_sel_q  <= lat_sel_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_a_d    = lat_a_q;
        lat_b_d    = lat_b_q;
        lat_sel_d  = lat_sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        op_count_d = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    lat_a_d   = cmd_a;
                    lat_b_d   = cmd_b;
                    lat_sel_d = cmd_sel;
                    if (is_legal(cmd_sel)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Illegal opcodes bypass the ALU, leaving its inputs untouched.
                        state_d    = ST_RESP;
                        rsp_data_d = 8'h00;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                alu_a_d   = lat_a_q;
                alu_b_d   = lat_b_q;
                alu_sel_d = lat_sel_q;
                cnt_d     = 4'h0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    rsp_data_d = alu_c;
                    rsp_err_d  = check_err;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a reference ALU on the alu_* pins (SETTLE_CYCLES=1).
// Define ALU_SEQ_CHECK_EN to exercise the golden-check build.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = 4'h0;
    logic [3:0] cmd_b = 4'h0;
    logic [3:0] cmd_sel = 4'h0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] op_count;
    logic       force_ff = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    function automatic logic [7:0] ref_alu(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] x;
        logic [7:0] y;
        x = {4'h0, a};
        y = {4'h0, b};
        case (s)
            4'b0000: return x + y;
            4'b1111: return x - y;
            4'b0001: return x & y;
            4'b0010: return x | y;
            4'b0100: return x ^ y;
            4'b1000: return (a == b) ? 8'h01 : 8'h00;
            4'b0011: return (a > b) ? 8'h01 : 8'h00;
            4'b0110: return x << b;
            4'b1100: return x >> b;
            4'b0101: return x * y;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_c = force_ff ? 8'hFF : ref_alu(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command/response; latency counts cycles from the accept edge to rsp_valid.
    task automatic transact(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] s, input logic [7:0] exp_data,
                            input logic exp_err, input int exp_lat);
        int lat;
        chk({tag, "_ready"}, {7'b0, cmd_ready}, 8'h01);
        cmd_a = a;
        cmd_b = b;
        cmd_sel = s;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 8'(lat), 8'(exp_lat));
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, {7'b0, rsp_err}, {7'b0, exp_err});
        $display("txn %s a=%h b=%h sel=%b data=%02h err=%0d lat=%0d", tag, a, b, s, rsp_data, rsp_err, lat);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, "_cnt"}, op_count, exp_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", {7'b0, cmd_ready}, 8'h01);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_err", {7'b0, rsp_err}, 8'h00);
        chk("rst_alu_a", {4'h0, alu_a}, 8'h00);
        chk("rst_alu_b", {4'h0, alu_b}, 8'h00);
        chk("rst_alu_sel", {4'h0, alu_sel}, 8'h00);
        chk("rst_op_count", op_count, 8'h00);

        // Legal opcodes
        transact("add", 4'b0010, 4'b1000, 4'b0000, 8'h0A, 1'b0, 3);
        chk("add_alu_a_hold", {4'h0, alu_a}, 8'h02);
        transact("mul", 4'b1011, 4'b0111, 4'b0101, 8'h4D, 1'b0, 3);
        transact("sub", 4'b0010, 4'b1000, 4'b1111, 8'hFA, 1'b0, 3);
        transact("shl", 4'b0101, 4'b0010, 4'b0110, 8'h14, 1'b0, 3);
        transact("gt", 4'b1001, 4'b0011, 4'b0011, 8'h01, 1'b0, 3);
        transact("xor", 4'b1100, 4'b1010, 4'b0100, 8'h06, 1'b0, 3);
        transact("sub2", 4'b0010, 4'b1000, 4'b1111, 8'hFA, 1'b0, 3);

        // Illegal opcode: ALU pins keep the previous (sub) values
        transact("illegal", 4'h3, 4'h4, 4'b0111, 8'h00, 1'b1, 1);
        chk("illegal_alu_sel", {4'h0, alu_sel}, 8'h0F);
        chk("illegal_alu_a", {4'h0, alu_a}, 8'h02);

        // Backpressure with a second command waiting
        cmd_a = 4'h3;
        cmd_b = 4'h4;
        cmd_sel = 4'b0000;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("bp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("bp_data0", rsp_data, 8'h07);
        cmd_a = 4'h1;
        cmd_b = 4'h1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", {7'b0, rsp_valid}, 8'h01);
            chk("bp_hold_data", rsp_data, 8'h07);
            chk("bp_hold_ready", {7'b0, cmd_ready}, 8'h00);
            chk("bp_hold_cnt", op_count, exp_cnt);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        $display("txn bp a=3 b=4 sel=0000 released op_count=%0d", op_count);
        chk("bp_release_cnt", op_count, exp_cnt);
        chk("bp_release_idle", {7'b0, cmd_ready}, 8'h01);
        chk("bp_release_valid", {7'b0, rsp_valid}, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("bp_next_accept", {7'b0, cmd_ready}, 8'h00);
        tick();
        tick();
        chk("bp_next_valid", {7'b0, rsp_valid}, 8'h01);
        chk("bp_next_data", rsp_data, 8'h02);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        $display("txn bp2 a=1 b=1 sel=0000 op_count=%0d", op_count);
        chk("bp_next_cnt", op_count, exp_cnt);

        // Forced wrong ALU result on eq
        force_ff = 1'b1;
`ifdef ALU_SEQ_CHECK_EN
        transact("chk_eq", 4'b1001, 4'b1001, 4'b1000, 8'hFF, 1'b1, 3);
`else
        transact("chk_eq", 4'b1001, 4'b1001, 4'b1000, 8'hFF, 1'b0, 3);
`endif
        force_ff = 1'b0;

        // Reset while in SETTLE, with handshakes active
        cmd_a = 4'h5;
        cmd_b = 4'h5;
        cmd_sel = 4'b0000;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_cnt = 8'h00;
        $display("txn rst_settle a=5 b=5 aborted");
        chk("rst_settle_valid", {7'b0, rsp_valid}, 8'h00);
        chk("rst_settle_ready", {7'b0, cmd_ready}, 8'h01);
        chk("rst_settle_cnt", op_count, 8'h00);
        chk("rst_settle_data", rsp_data, 8'h00);

        // 256 completions wrap op_count back to zero
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'(i);
            b = 4'(i >> 4);
            transact("wrap", a, b, 4'b0000, {4'h0, a} + {4'h0, b}, 1'b0, 3);
        end
        chk("wrap_final", op_count, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
